alu_result_buffer: RTL and testbench
====================================

Name: alu_result_buffer

Overview:
- Downstream consumer of the single-cycle ALU stage.
- Captures each completed result, tagged with the opcode that produced it, into a small in-order FIFO.
- Presents entries to the bus/scoreboard side over a valid/ready interface.
- Tracks results dropped on overflow, so that a consumer which stalls cannot lose data silently.

Parameters:
- DEPTH, 4, number of FIFO entries; must be a power of 2, minimum 2.
- DROP_W, 8, width of the saturating dropped-result counter.

Ports:
- clk  in  1  sole clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- done_in  in  1  completion pulse from the ALU stage; result_in and op_in are valid in the same cycle.
- result_in  in  16  ALU result.
- op_in  in  3  opcode held by the requester while done_in is high.
- out_valid  out  1  head entry available.
- out_ready  in  1  consumer accepts the head entry when out_valid && out_ready.
- out_result  out  16  head entry result.
- out_op  out  3  head entry opcode.
- count  out  $clog2(DEPTH+1)  current occupancy.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- overflow  out  1  sticky; set when a result is dropped.
- drop_cnt  out  DROP_W  number of dropped results; saturates at all-ones.
- clr_overflow  in  1  synchronous clear of overflow and drop_cnt.

Behaviour:
- Reset (async assert, sync release on clk):
  - pointers, count, overflow and drop_cnt = 0
  - out_valid = 0, empty = 1, full = 0
  - out_result = 0, out_op = 0
- Storage contents are don't-care after reset, but outputs must read 0 while empty.
- Push condition: done_in && (!full || pop), where pop = out_valid && out_ready.
- Push latency: a pushed entry becomes visible at the head no earlier than the next cycle. There is no combinational fall-through from done_in to out_valid.
- Pop: the head advances on the cycle pop is true. out_result/out_op change only on pop, or on a push into an empty FIFO.
- Ordering: strict FIFO. Entries leave in capture order.
- Simultaneous push and pop:
  - count unchanged
  - legal when full: the popped slot is reused
  - legal when count == 1: the new entry becomes head next cycle
- Pointer wrap: read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Full and empty are derived from count, not from pointer compare.
- Drop: done_in && full && !pop.
  - Entry is discarded and FIFO contents are unchanged.
  - overflow <= 1.
  - drop_cnt <= drop_cnt + 1, saturating at 2^DROP_W - 1.
- clr_overflow:
  - overflow <= 0 and drop_cnt <= 0 next cycle.
  - If a drop occurs in the same cycle, the drop wins: overflow = 1, drop_cnt = 1.
- done_in when op_in == 3'b000 is captured as-is. The block does not filter; the ALU never asserts done for NOP.
- out_ready while out_valid == 0 is ignored.
- Reset mid-operation: all entries are lost immediately and the outputs return to reset values asynchronously.
- count, full and empty are registered and coherent with out_valid in every cycle: out_valid == !empty.

Decomposition:
- Shared package alu_pkg holds:
  - opcode constants: OP_NOP = 3'b000, OP_ADD = 3'b001, OP_AND = 3'b010, OP_XOR = 3'b011, OP_MUL = 3'b100
  - typedef alu_result_t: packed struct {op[2:0], result[15:0]}
- One sub-module, alu_rb_storage:
  - DEPTH x 19-bit register array with write port (we, waddr, wdata) and read port (raddr, rdata)
  - no reset on the array
- Pointer, count and overflow logic stay in the top module.

Test Plan:
- Single capture: done_in=1, op_in=001, result_in=16'h01FE for one cycle, out_ready=0 -> next cycle out_valid=1, out_op=001, out_result=01FE, count=1. Then out_ready=1 for one cycle -> empty=1, out_valid=0.
- Fill and order: 4 pushes with results 0x0011, 0x0022, 0x0033, 0x0044 and ops 001/010/011/001, out_ready=0 -> full=1, count=4. Drain with out_ready=1 -> entries appear in the same order, one per cycle.
- Overflow: with the FIFO full and out_ready=0, apply 3 further done_in pulses -> overflow=1, drop_cnt=3, contents unchanged. Pulse clr_overflow -> overflow=0, drop_cnt=0.
- Push+pop at full: FIFO full, done_in=1 (result 0x0055) with out_ready=1 in the same cycle -> no drop, count stays 4, 0x0055 emerges last after draining.
- Saturation and clear race:
  - 300 drops -> drop_cnt=255.
  - clr_overflow coincident with a drop -> overflow=1, drop_cnt=1.
- Async reset mid-stream: count=3, assert reset_n=0 between clock edges -> out_valid=0, count=0, overflow=0 immediately. After release, the first push is read back correctly with the pointers wrapping from 0.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Opcode constants and result record shared by the ALU result
//               buffer and its storage.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;

    typedef struct packed {
        logic [2:0]  op;
        logic [15:0] result;
    } alu_result_t;

endpackage
`default_nettype wire

// File: rtl/alu_result_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_result_buffer_if
// Description : Capture, head-of-queue and overflow-status signals of the
//               ALU result buffer.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_result_buffer_if #(
    parameter int DEPTH  = 4,
    parameter int DROP_W = 8
);
    logic                         done_in;
    logic [15:0]                  result_in;
    logic [2:0]                   op_in;
    logic                         out_valid;
    logic                         out_ready;
    logic [15:0]                  out_result;
    logic [2:0]                   out_op;
    logic [$clog2(DEPTH+1)-1:0]   count;
    logic                         full;
    logic                         empty;
    logic                         overflow;
    logic [DROP_W-1:0]            drop_cnt;
    logic                         clr_overflow;

    modport master (
        output done_in, result_in, op_in, out_ready, clr_overflow,
        input  out_valid, out_result, out_op, count, full, empty,
               overflow, drop_cnt
    );

    modport slave (
        input  done_in, result_in, op_in, out_ready, clr_overflow,
        output out_valid, out_result, out_op, count, full, empty,
               overflow, drop_cnt
    );
endinterface
`default_nettype wire

// File: rtl/alu_rb_storage.sv
`default_nettype none
// ============================================================================
// Module      : alu_rb_storage
// Description : DEPTH x 19-bit register array, one write and one async read port.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_rb_storage
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            we_i,
    input  logic [AW-1:0]   waddr_i,
    input  alu_result_t     wdata_i,
    input  logic [AW-1:0]   raddr_i,
    output alu_result_t     rdata_o
);

    alu_result_t mem_q [DEPTH];

    // Contents need no reset: the top masks the read data while empty.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/alu_result_buffer.sv
`default_nettype none
// ============================================================================
// Module      : alu_result_buffer
// Description : In-order FIFO of opcode-tagged ALU results with sticky
//               overflow flag and saturating dropped-result counter.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_result_buffer
    import alu_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DROP_W = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    alu_result_buffer_if.slave   bus
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [c_CNT_W-1:0] c_DEPTH = c_CNT_W'(DEPTH);

    logic [c_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_CNT_W-1:0] count_q,  count_d;
    logic               full_q,   full_d;
    logic               empty_q,  empty_d;
    logic               overflow_q, overflow_d;
    logic [DROP_W-1:0]  drop_cnt_q, drop_cnt_d;

    logic        w_pop;
    logic        w_push;
    logic        w_drop;
    alu_result_t w_wdata;
    alu_result_t w_rdata;

    // A pop frees a slot this cycle, so a push into a full FIFO is accepted.
    assign w_pop  = !empty_q && bus.out_ready;
    assign w_push = bus.done_in && (!full_q || w_pop);
    assign w_drop = bus.done_in && full_q && !w_pop;

    assign w_wdata.op     = bus.op_in;
    assign w_wdata.result = bus.result_in;

    alu_rb_storage #(
        .DEPTH (DEPTH)
    ) u_storage (
        .clk     (clk),
        .we_i    (w_push),
        .waddr_i (wr_ptr_q),
        .wdata_i (w_wdata),
        .raddr_i (rd_ptr_q),
        .rdata_o (w_rdata)
    );

    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;

        if (w_push) begin
            wr_ptr_d = wr_ptr_q + c_PTR_W'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + c_PTR_W'(1);
        end

        case ({w_push, w_pop})
            2'b10:   count_d = count_q + c_CNT_W'(1);
            2'b01:   count_d = count_q - c_CNT_W'(1);
            default: count_d = count_q;
        endcase

        // A drop in the same cycle as a clear restarts the tally at one.
        if (w_drop) begin
            overflow_d = 1'b1;
            if (bus.clr_overflow) begin
                drop_cnt_d = DROP_W'(1);
            end else if (drop_cnt_q != {DROP_W{1'b1}}) begin
                drop_cnt_d = drop_cnt_q + DROP_W'(1);
            end
        end else if (bus.clr_overflow) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end

        full_d  = (count_d == c_DEPTH);
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign bus.out_valid  = !empty_q;
    assign bus.out_result = empty_q ? 16'h0000 : w_rdata.result;
    assign bus.out_op     = empty_q ? 3'b000   : w_rdata.op;
    assign bus.count      = count_q;
    assign bus.full       = full_q;
    assign bus.empty      = empty_q;
    assign bus.overflow   = overflow_q;
    assign bus.drop_cnt   = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_result_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_result_buffer
// Description : Directed, table-driven self-checking bench for alu_result_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_result_buffer;

    logic clk;
    logic reset_n;
    int   n_cmp;
    int   n_bad;

    alu_result_buffer_if #(.DEPTH(4), .DROP_W(8)) bus ();

    alu_result_buffer #(
        .DEPTH  (4),
        .DROP_W (8)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        done;
        logic [15:0] res;
        logic [2:0]  op;
        logic        rdy;
        logic        clr;
        logic [33:0] exp;
    } vec_t;

    vec_t vt [23];

    // {valid, result, op, count, full, empty, overflow, drop_cnt}
    function automatic logic [33:0] ex(logic v, logic [15:0] r, logic [2:0] o,
                                       logic [2:0] c, logic f, logic e,
                                       logic ov, logic [7:0] d);
        return {v, r, o, c, f, e, ov, d};
    endfunction

    function automatic vec_t mk(logic d, logic [15:0] r, logic [2:0] o,
                                logic rdy, logic clr, logic [33:0] e);
        vec_t t;
        t.done = d; t.res = r; t.op = o; t.rdy = rdy; t.clr = clr; t.exp = e;
        return t;
    endfunction

    function automatic logic [33:0] actual();
        return {bus.out_valid, bus.out_result, bus.out_op, bus.count,
                bus.full, bus.empty, bus.overflow, bus.drop_cnt};
    endfunction

    task automatic check(input string name, input logic [33:0] exp);
        logic [33:0] act;
        act = actual();
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got v=%0b res=%h op=%0d cnt=%0d full=%0b empty=%0b ovf=%0b drop=%0d, expected v=%0b res=%h op=%0d cnt=%0d full=%0b empty=%0b ovf=%0b drop=%0d",
                     name, act[33], act[32:17], act[16:14], act[13:11], act[10], act[9], act[8], act[7:0],
                     exp[33], exp[32:17], exp[16:14], exp[13:11], exp[10], exp[9], exp[8], exp[7:0]);
        end
    endtask

    task automatic drive(input logic d, input logic [15:0] r, input logic [2:0] o,
                         input logic rdy, input logic clr);
        bus.done_in      = d;
        bus.result_in    = r;
        bus.op_in        = o;
        bus.out_ready    = rdy;
        bus.clr_overflow = clr;
    endtask

    task automatic step(input string name, input logic [33:0] exp);
        @(posedge clk);
        #1;
        check(name, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;

        vt[0]  = mk(1, 16'h01FE, 3'd1, 0, 0, ex(1, 16'h01FE, 3'd1, 3'd1, 0, 0, 0, 8'd0));
        vt[1]  = mk(0, 16'h0000, 3'd0, 1, 0, ex(0, 16'h0000, 3'd0, 3'd0, 0, 1, 0, 8'd0));
        vt[2]  = mk(1, 16'h0011, 3'd1, 0, 0, ex(1, 16'h0011, 3'd1, 3'd1, 0, 0, 0, 8'd0));
        vt[3]  = mk(1, 16'h0022, 3'd2, 0, 0, ex(1, 16'h0011, 3'd1, 3'd2, 0, 0, 0, 8'd0));
        vt[4]  = mk(1, 16'h0033, 3'd3, 0, 0, ex(1, 16'h0011, 3'd1, 3'd3, 0, 0, 0, 8'd0));
        vt[5]  = mk(1, 16'h0044, 3'd1, 0, 0, ex(1, 16'h0011, 3'd1, 3'd4, 1, 0, 0, 8'd0));
        vt[6]  = mk(1, 16'h0099, 3'd4, 0, 0, ex(1, 16'h0011, 3'd1, 3'd4, 1, 0, 1, 8'd1));
        vt[7]  = mk(1, 16'h0099, 3'd4, 0, 0, ex(1, 16'h0011, 3'd1, 3'd4, 1, 0, 1, 8'd2));
        vt[8]  = mk(1, 16'h0099, 3'd4, 0, 0, ex(1, 16'h0011, 3'd1, 3'd4, 1, 0, 1, 8'd3));
        vt[9]  = mk(0, 16'h0000, 3'd0, 0, 1, ex(1, 16'h0011, 3'd1, 3'd4, 1, 0, 0, 8'd0));
        vt[10] = mk(1, 16'h0055, 3'd4, 1, 0, ex(1, 16'h0022, 3'd2, 3'd4, 1, 0, 0, 8'd0));
        vt[11] = mk(0, 16'h0000, 3'd0, 1, 0, ex(1, 16'h0033, 3'd3, 3'd3, 0, 0, 0, 8'd0));
        vt[12] = mk(0, 16'h0000, 3'd0, 1, 0, ex(1, 16'h0044, 3'd1, 3'd2, 0, 0, 0, 8'd0));
        vt[13] = mk(0, 16'h0000, 3'd0, 1, 0, ex(1, 16'h0055, 3'd4, 3'd1, 0, 0, 0, 8'd0));
        vt[14] = mk(0, 16'h0000, 3'd0, 1, 0, ex(0, 16'h0000, 3'd0, 3'd0, 0, 1, 0, 8'd0));
        vt[15] = mk(1, 16'h0066, 3'd2, 0, 0, ex(1, 16'h0066, 3'd2, 3'd1, 0, 0, 0, 8'd0));
        vt[16] = mk(1, 16'h0077, 3'd3, 1, 0, ex(1, 16'h0077, 3'd3, 3'd1, 0, 0, 0, 8'd0));
        vt[17] = mk(0, 16'h0000, 3'd0, 1, 0, ex(0, 16'h0000, 3'd0, 3'd0, 0, 1, 0, 8'd0));
        vt[18] = mk(1, 16'h1234, 3'd0, 0, 0, ex(1, 16'h1234, 3'd0, 3'd1, 0, 0, 0, 8'd0));
        vt[19] = mk(0, 16'h0000, 3'd0, 1, 0, ex(0, 16'h0000, 3'd0, 3'd0, 0, 1, 0, 8'd0));
        vt[20] = mk(0, 16'h0000, 3'd0, 1, 0, ex(0, 16'h0000, 3'd0, 3'd0, 0, 1, 0, 8'd0));
        vt[21] = mk(1, 16'h0088, 3'd1, 1, 0, ex(1, 16'h0088, 3'd1, 3'd1, 0, 0, 0, 8'd0));
        vt[22] = mk(0, 16'h0000, 3'd0, 1, 0, ex(0, 16'h0000, 3'd0, 3'd0, 0, 1, 0, 8'd0));

        reset_n = 1'b0;
        drive(0, 16'h0000, 3'd0, 0, 0);
        #12;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_state", ex(0, 16'h0000, 3'd0, 3'd0, 0, 1, 0, 8'd0));

        for (int i = 0; i < 23; i++) begin
            drive(vt[i].done, vt[i].res, vt[i].op, vt[i].rdy, vt[i].clr);
            step($sformatf("vec%0d", i), vt[i].exp);
        end

        // Fill, then hold the consumer off for 300 drops.
        for (int i = 0; i < 4; i++) begin
            drive(1, 16'h0100 + 16'(i), 3'd2, 0, 0);
            step($sformatf("sat_fill%0d", i),
                 ex(1, 16'h0100, 3'd2, 3'(i + 1), (i == 3), 0, 0, 8'd0));
        end
        for (int i = 0; i < 300; i++) begin
            drive(1, 16'hDEAD, 3'd4, 0, 0);
            @(posedge clk);
            #1;
        end
        check("drop_saturate", ex(1, 16'h0100, 3'd2, 3'd4, 1, 0, 1, 8'd255));

        drive(1, 16'hDEAD, 3'd4, 0, 1);
        step("clr_drop_race", ex(1, 16'h0100, 3'd2, 3'd4, 1, 0, 1, 8'd1));

        drive(0, 16'h0000, 3'd0, 1, 0);
        step("pop_to_three", ex(1, 16'h0101, 3'd2, 3'd3, 0, 0, 1, 8'd1));

        // Asynchronous reset between clock edges.
        drive(0, 16'h0000, 3'd0, 0, 0);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset", ex(0, 16'h0000, 3'd0, 3'd0, 0, 1, 0, 8'd0));
        @(negedge clk);
        check("reset_held", ex(0, 16'h0000, 3'd0, 3'd0, 0, 1, 0, 8'd0));
        reset_n = 1'b1;

        drive(1, 16'hBEEF, 3'd4, 0, 0);
        step("post_reset_push", ex(1, 16'hBEEF, 3'd4, 3'd1, 0, 0, 0, 8'd0));

        // Push and pop together for more than DEPTH cycles to wrap pointers.
        for (int i = 0; i < 6; i++) begin
            drive(1, 16'hA000 + 16'(i), 3'(i), 1, 0);
            step($sformatf("wrap%0d", i),
                 ex(1, 16'hA000 + 16'(i), 3'(i), 3'd1, 0, 0, 0, 8'd0));
        end
        drive(0, 16'h0000, 3'd0, 1, 0);
        step("final_drain", ex(0, 16'h0000, 3'd0, 3'd0, 0, 1, 0, 8'd0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
